// File: rtl/sdram32_pkg.sv
// Shared definitions for the 32-bit SDR SDRAM responder: command codes,
// error codes, array geometry and the byte-lane mask helper.
package sdram32_pkg;

   localparam int ROW_BITS  = 11;
   localparam int COL_BITS  = 8;
   localparam int BANK_BITS = 2;
   localparam int NUM_BANKS = 1 << BANK_BITS;

   // {RASn, CASn, WEn} with CSn low
   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BST = 3'b110,
      CMD_NOP = 3'b111
   } cmd_t;

   localparam logic [2:0] ERR_NONE        = 3'd0;
   localparam logic [2:0] ERR_BANK_CLOSED = 3'd1;
   localparam logic [2:0] ERR_ACT_OPEN    = 3'd2;
   localparam logic [2:0] ERR_REF_OPEN    = 3'd3;
   localparam logic [2:0] ERR_MODE_BAD    = 3'd4;
   localparam logic [2:0] ERR_TRCD        = 3'd5;
   localparam logic [2:0] ERR_NO_MODE     = 3'd6;
   localparam logic [2:0] ERR_CONTENTION  = 3'd7;

   // Zero every byte lane whose DQM bit is set
   function automatic logic [31:0] maskLanes(input logic [31:0] data, input logic [3:0] dqm);
      logic [31:0] result;
      result = data;
      for (int i = 0; i < 4; i++) begin
         if (dqm[i]) result[8*i +: 8] = 8'h00;
      end
      return result;
   endfunction

endpackage

// File: rtl/sdram32_bank.sv
// One SDRAM bank's row state: open flag, open row and a saturating
// counter of cycles since the last ACTIVE for the tRCD check.
module sdram32_bank
   import sdram32_pkg::*;
#(
   parameter int TRCD = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_activate,
   input  logic                i_precharge,
   input  logic                i_access,
   input  logic                i_autoPre,
   input  logic [ROW_BITS-1:0] i_row,
   output logic                o_open,
   output logic [ROW_BITS-1:0] o_row,
   output logic                o_trcdOk
);

   localparam logic [7:0] TRCD_SAT = 8'(TRCD);

   logic                r_open;
   logic [ROW_BITS-1:0] r_row;
   logic [7:0]          r_trcdCnt;

   // The activating edge itself counts as one elapsed cycle once the next
   // edge arrives, so the counter restarts at 1 and saturates at TRCD.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_open    <= 1'b0;
         r_row     <= '0;
         r_trcdCnt <= 8'd0;
      end else if (i_activate) begin
         r_open    <= 1'b1;
         r_row     <= i_row;
         r_trcdCnt <= 8'd1;
      end else begin
         if (i_precharge || (i_access && i_autoPre)) r_open <= 1'b0;
         if (r_trcdCnt < TRCD_SAT) r_trcdCnt <= r_trcdCnt + 8'd1;
      end
   end

   assign o_open   = r_open;
   assign o_row    = r_row;
   assign o_trcdOk = (r_trcdCnt >= TRCD_SAT);

endmodule

// File: rtl/sdram32_model.sv
// Cycle-accurate SDR SDRAM responder: command decode, mode register,
// four bank trackers, backing store, CAS-latency read pipeline and a
// sticky first-error latch.
module sdram32_model
   import sdram32_pkg::*;
#(
   parameter int MEM_ADDR_BITS = 21,
   parameter int TRCD          = 2,
   parameter int DEFAULT_CL    = 2
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        CSn,
   input  logic        RASn,
   input  logic        CASn,
   input  logic        WEn,
   input  logic [1:0]  BA,
   input  logic [10:0] A,
   input  logic [3:0]  DQM,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        Dout_En,
   output logic        mode_ok,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [15:0] refresh_cnt
);

   localparam int IDX_BITS = BANK_BITS + ROW_BITS + COL_BITS;

   cmd_t                w_cmd;
   logic                w_isAct, w_isRd, w_isWr, w_isPre, w_isRef, w_isLmr, w_needsMode;
   logic                w_modeLegal, w_anyOpen, w_selOpen, w_selTrcdOk, w_rdAccept, w_pending;
   logic [3:0]          w_bankOpen, w_bankTrcdOk;
   logic [ROW_BITS-1:0] w_bankRow [NUM_BANKS];
   logic [ROW_BITS-1:0] w_selRow;
   logic [IDX_BITS-1:0] w_fullIdx;
   logic [MEM_ADDR_BITS-1:0] w_memIdx;
   logic [31:0]         w_rdData;
   logic [1:0]          w_slot;
   logic [7:1]          w_errHit;
   logic [2:0]          w_errCode;
   logic                w_unusedBits;

   logic [31:0] r_mem [0:(1 << MEM_ADDR_BITS) - 1];
   logic [2:0]  r_cl;
   logic        r_modeOk;
   logic [2:0]  r_pipeVld;
   logic [31:0] r_pipeData [3];
   logic [31:0] r_dout;
   logic        r_doutEn;
   logic        r_err;
   logic [2:0]  r_errCode;
   logic [15:0] r_refreshCnt;

   assign w_cmd       = CSn ? CMD_NOP : cmd_t'({RASn, CASn, WEn});
   assign w_isAct     = (w_cmd == CMD_ACT);
   assign w_isRd      = (w_cmd == CMD_RD);
   assign w_isWr      = (w_cmd == CMD_WR);
   assign w_isPre     = (w_cmd == CMD_PRE);
   assign w_isRef     = (w_cmd == CMD_REF);
   assign w_isLmr     = (w_cmd == CMD_LMR);
   assign w_needsMode = (w_cmd != CMD_NOP) && (w_cmd != CMD_LMR);
   assign w_modeLegal = ((A[6:4] == 3'd2) || (A[6:4] == 3'd3)) && (A[2:0] == 3'b000);
   assign w_unusedBits = ^{A[9:8], A[3]};

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sdram32_bank #(.TRCD(TRCD)) u_bank (
         .i_clk       (m_clock),
         .i_reset     (p_reset),
         .i_activate  (w_isAct && (BA == 2'(b))),
         .i_precharge (w_isPre && (A[10] || (BA == 2'(b)))),
         .i_access    ((w_isRd || w_isWr) && (BA == 2'(b))),
         .i_autoPre   (A[10]),
         .i_row       (A),
         .o_open      (w_bankOpen[b]),
         .o_row       (w_bankRow[b]),
         .o_trcdOk    (w_bankTrcdOk[b])
      );
   end

   assign w_anyOpen   = |w_bankOpen;
   assign w_selOpen   = w_bankOpen[BA];
   assign w_selTrcdOk = w_bankTrcdOk[BA];
   assign w_selRow    = w_bankRow[BA];
   assign w_fullIdx   = {BA, w_selRow, A[COL_BITS-1:0]};
   assign w_memIdx    = w_fullIdx[MEM_ADDR_BITS-1:0];
   assign w_rdData    = maskLanes(r_mem[w_memIdx], DQM);
   assign w_rdAccept  = w_isRd && w_selOpen;
   assign w_pending   = |r_pipeVld;
   assign w_slot      = 2'(r_cl - 3'd1);

   // Collect every protocol violation of this edge; the lowest code wins
   always_comb begin
      w_errHit = '0;
      if ((w_isRd || w_isWr) && !w_selOpen) w_errHit[1] = 1'b1;
      if ((w_isRd || w_isWr) && w_selOpen && !w_selTrcdOk) w_errHit[5] = 1'b1;
      if (w_isAct && w_selOpen) w_errHit[2] = 1'b1;
      if (w_isRef && w_anyOpen) w_errHit[3] = 1'b1;
      if (w_isLmr && !w_anyOpen && !w_modeLegal) w_errHit[4] = 1'b1;
      if (w_needsMode && !r_modeOk) w_errHit[6] = 1'b1;
      if (w_isWr && w_pending) w_errHit[7] = 1'b1;
      w_errCode = ERR_NONE;
      for (int i = 7; i >= 1; i--) begin
         if (w_errHit[i]) w_errCode = 3'(i);
      end
   end

   // Backing store is never cleared; writes honour the per-lane DQM mask
   always_ff @(posedge m_clock) begin
      if (!p_reset && w_isWr && w_selOpen) begin
         for (int i = 0; i < 4; i++) begin
            if (!DQM[i]) r_mem[w_memIdx][8*i +: 8] <= Din[8*i +: 8];
         end
      end
   end

   // Mode register: a LOAD MODE is only taken with every bank closed
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_cl     <= 3'(DEFAULT_CL);
         r_modeOk <= 1'b0;
      end else if (w_isLmr && !w_anyOpen && w_modeLegal) begin
         r_cl     <= A[6:4];
         r_modeOk <= 1'b1;
      end
   end

   // Read pipeline: data enters at slot CL-1 and reaches Dout CL edges later
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_pipeVld  <= 3'b000;
         r_pipeData <= '{default: 32'h0};
         r_dout     <= 32'h0;
         r_doutEn   <= 1'b0;
      end else begin
         r_dout        <= r_pipeVld[0] ? r_pipeData[0] : 32'h0;
         r_doutEn      <= r_pipeVld[0];
         r_pipeVld     <= {1'b0, r_pipeVld[2:1]};
         r_pipeData[0] <= r_pipeData[1];
         r_pipeData[1] <= r_pipeData[2];
         r_pipeData[2] <= 32'h0;
         if (w_rdAccept) begin
            r_pipeVld[w_slot]  <= 1'b1;
            r_pipeData[w_slot] <= w_rdData;
         end
      end
   end

   // First error is latched until reset; refresh count wraps naturally
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         r_err        <= 1'b0;
         r_errCode    <= ERR_NONE;
         r_refreshCnt <= 16'd0;
      end else begin
         if (!r_err && (w_errCode != ERR_NONE)) begin
            r_err     <= 1'b1;
            r_errCode <= w_errCode;
         end
         if (w_isRef) r_refreshCnt <= r_refreshCnt + 16'd1;
      end
   end

   assign Dout        = r_dout;
   assign Dout_En     = r_doutEn;
   assign mode_ok     = r_modeOk;
   assign err         = r_err;
   assign err_code    = r_errCode;
   assign refresh_cnt = r_refreshCnt;

endmodule

// File: doc/sdram32_model.md
Name: sdram32_model

Overview:
- Cycle-accurate responder for the 32-bit single-data-rate SDRAM command interface: 4 banks x 2048 rows x 256 columns x 32 bits.
- Decodes CSn/RASn/CASn/WEn commands, tracks the open row per bank and returns read data after the programmed CAS latency.
- Checks protocol rules and latches a sticky error code.
- Sits on the memory side of the SDRAM controller; used as the bench/simulation stand-in for the on-package SDRAM.

Parameters:
- MEM_ADDR_BITS, 21, backing-store index width; the {BA,row,col} index is truncated to its low bits, so smaller values alias.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- DEFAULT_CL, 2, CAS latency used until a LOAD MODE command is accepted.

Ports:
- m_clock  in  1  single clock; all state changes on its rising edge.
- p_reset  in  1  synchronous, active-high reset.
- CSn  in  1  chip select, active low.
- RASn  in  1  row address strobe, active low.
- CASn  in  1  column address strobe, active low.
- WEn  in  1  write enable, active low.
- BA  in  2  bank address.
- A  in  11  row address, or column in A[7:0]; A[10] selects auto-precharge / precharge-all.
- DQM  in  4  byte masks, 1 = masked.
- Din  in  32  write data from the controller, sampled together with WRITE.
- Dout  out  32  read data.
- Dout_En  out  1  high while Dout carries valid read data.
- mode_ok  out  1  high once a valid LOAD MODE has been accepted.
- err  out  1  sticky protocol error flag.
- err_code  out  3  code of the first error; 0 = none.
- refresh_cnt  out  16  count of accepted AUTO REFRESH commands; wraps at 16 bits.

Behaviour:
- Reset: Dout=0, Dout_En=0, mode_ok=0, err=0, err_code=0, refresh_cnt=0. All banks closed, read pipeline flushed, CL=DEFAULT_CL. The memory array is not cleared.
- Decode with CSn=0, {RASn,CASn,WEn}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE
  - 001 AUTO REFRESH
  - 000 LOAD MODE
  - 110 BURST TERMINATE (accepted, no effect)
- CSn=1 is NOP.
- LOAD MODE:
  - Accepted only when all banks are closed.
  - CL=A[6:4]; legal values are 2 or 3.
  - Burst length A[2:0] must be 000.
  - Legal load sets mode_ok=1. An illegal field gives error 4 and leaves the mode unchanged.
- ACTIVE: opens row A on bank BA and restarts that bank's tRCD counter.
- READ/WRITE:
  - Column A[7:0].
  - The bank must be open (else error 1, access ignored).
  - At least TRCD cycles must have elapsed since ACTIVE (else error 5, access still performed).
  - A[10]=1 closes the bank after the access.
- WRITE:
  - Byte lane i is written only when DQM[i]=0.
  - The write is visible to a READ issued on the next cycle.
- READ:
  - Data is captured at the READ edge.
  - DQM is sampled with the READ; masked lanes return 0.
  - Dout/Dout_En are valid exactly CL cycles after the READ edge, for one cycle.
  - Back-to-back READs give back-to-back data with no bubbles.
- PRECHARGE: A[10]=1 closes all banks; otherwise closes bank BA. Precharging a closed bank is legal.
- AUTO REFRESH: requires all banks closed (else error 3); increments refresh_cnt either way.
- Any command other than NOP or LOAD MODE while mode_ok=0 gives error 6.
- ACTIVE to an already-open bank gives error 2; the row is replaced.
- WRITE issued while read data is still pending in the pipeline (bus contention) gives error 7; the write is still performed.
- Error reporting:
  - err and err_code latch on the first error; later errors do not overwrite.
  - Errors clear only on p_reset.
  - When several errors occur on the same edge, the lowest code wins.
- Reset mid-read: the pipeline is discarded and Dout_En=0 on the next cycle.

Decomposition:
- Shared package sdram32_pkg holds:
  - command encodings (3-bit {RASn,CASn,WEn});
  - error code constants 1..7;
  - geometry constants: ROW_BITS=11, COL_BITS=8, BANK_BITS=2.
- Sub-module sdram32_bank, instantiated 4 times:
  - holds the open flag, row register and tRCD saturating counter;
  - inputs: activate, precharge, access strobe;
  - outputs: open, row, trcd_ok.
- Top level holds command decode, mode register, read pipeline (shift register of depth 3), memory array and error latch.

Test Plan:
- LOAD MODE A=0x020 (CL=2), ACTIVE BA=1 row 0x123, 2 NOPs, WRITE col 0x45 Din=0xDEADBEEF DQM=0, READ col 0x45 -> Dout=0xDEADBEEF with Dout_En high exactly 2 cycles after the READ edge; err=0.
- With CL=3, WRITE 0x11223344 then WRITE 0xAABBCCDD with DQM=0101 to the same address, then READ -> Dout=0xAA22CC44 3 cycles after the READ.
- READ to a closed bank -> err=1, err_code=1, Dout_En stays 0. A following ACTIVE to an open bank leaves err_code=1.
- ACTIVE then READ on the very next cycle (TRCD=2) -> err_code=5, and data is still returned after CL.
- 3 AUTO REFRESH with all banks closed -> refresh_cnt=3, err=0. ACTIVE then AUTO REFRESH -> err_code=3, refresh_cnt=4.
- Assert p_reset one cycle after a READ with CL=3 -> Dout_En never asserts, mode_ok=0. After a fresh LOAD MODE, the previously written data reads back intact.
